// File: rtl/div_pkg.sv
// Shared types and width helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int DD_W_DEF = 16;
  localparam int DV_W_DEF = 8;

  // The counter must hold DD_W itself, hence the +1.
  function automatic int cnt_width(input int dd_w);
    return $clog2(dd_w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DD_W_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int DV_W = 8
) (
  input  logic [DV_W:0]   p_in,
  input  logic            next_bit,
  input  logic [DV_W-1:0] dv_mag,
  output logic [DV_W:0]   p_out,
  output logic            q_bit
);

  logic [DV_W+1:0] trial;

  // One extra bit keeps the borrow visible as the sign of the trial result.
  always_comb begin
    trial = {p_in, next_bit} - {2'b00, dv_mag};
    q_bit = ~trial[DV_W+1];
    p_out = q_bit ? trial[DV_W:0] : {p_in[DV_W-1:0], next_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned restoring divider with go/done four-phase handshake.
// Define DIV_REMAINDER_EN to expose the remainder port and its sign-fix logic.
module seq_divider
  import div_pkg::*;
#(
  parameter int DD_W = 16,
  parameter int DV_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic            sign_mode,
  input  logic [DD_W-1:0] dd_in,
  input  logic [DV_W-1:0] dv_in,
  output logic [DD_W-1:0] quotient,
`ifdef DIV_REMAINDER_EN
  output logic [DV_W-1:0] remainder,
`endif
  output logic            done,
  output logic            div_zero,
  output logic            ovf
);

  localparam int CNT_W = cnt_width(DD_W);

  div_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DD_W-1:0] q_sh;
  logic [DV_W:0]   p_r, p_nxt;
  logic [DV_W-1:0] dv_mag_r;
  logic            q_neg_r, ovf_pend_r;
  logic            q_bit;
  logic            start, zero_start, step_en, fix_en;
  logic            dd_neg, dv_neg, ovf_det;
  logic [DD_W-1:0] dd_mag;
  logic [DV_W-1:0] dv_mag;
`ifdef DIV_REMAINDER_EN
  logic            rem_neg_r;
`endif

  // MIN maps onto itself under negation, which is exactly its unsigned magnitude.
  always_comb begin
    dd_neg  = sign_mode & dd_in[DD_W-1];
    dv_neg  = sign_mode & dv_in[DV_W-1];
    dd_mag  = dd_neg ? ({DD_W{1'b0}} - dd_in) : dd_in;
    dv_mag  = dv_neg ? ({DV_W{1'b0}} - dv_in) : dv_in;
    ovf_det = sign_mode && (dd_in == {1'b1, {(DD_W-1){1'b0}}}) && (dv_in == {DV_W{1'b1}});
  end

  div_step #(.DV_W(DV_W)) u_step (
    .p_in     (p_r),
    .next_bit (q_sh[DD_W-1]),
    .dv_mag   (dv_mag_r),
    .p_out    (p_nxt),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    zero_start = 1'b0;
    step_en    = 1'b0;
    fix_en     = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          if (dv_in == '0) begin
            zero_start = 1'b1;
            state_nxt  = DONE;
          end else begin
            start     = 1'b1;
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        step_en = 1'b1;
        if (cnt == '0) state_nxt = FIX;
      end
      FIX: begin
        fix_en    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (!go) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // q_sh holds the dividend magnitude and fills with quotient bits from the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      done       <= 1'b1;
      quotient   <= '0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
      cnt        <= '0;
      q_sh       <= '0;
      p_r        <= '0;
      dv_mag_r   <= '0;
      q_neg_r    <= 1'b0;
      ovf_pend_r <= 1'b0;
`ifdef DIV_REMAINDER_EN
      remainder  <= '0;
      rem_neg_r  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (start) begin
        done       <= 1'b0;
        div_zero   <= 1'b0;
        ovf        <= 1'b0;
        cnt        <= CNT_W'(DD_W - 1);
        q_sh       <= dd_mag;
        p_r        <= '0;
        dv_mag_r   <= dv_mag;
        q_neg_r    <= dd_neg ^ dv_neg;
        ovf_pend_r <= ovf_det;
`ifdef DIV_REMAINDER_EN
        rem_neg_r  <= dd_neg;
`endif
      end
      if (zero_start) begin
        done      <= 1'b0;
        div_zero  <= 1'b1;
        ovf       <= 1'b0;
        quotient  <= '1;
`ifdef DIV_REMAINDER_EN
        remainder <= dd_in[DV_W-1:0];
`endif
      end
      if (step_en) begin
        q_sh <= {q_sh[DD_W-2:0], q_bit};
        p_r  <= p_nxt;
        cnt  <= cnt - 1'b1;
      end
      if (fix_en) begin
        quotient  <= q_neg_r ? ({DD_W{1'b0}} - q_sh) : q_sh;
        ovf       <= ovf_pend_r;
`ifdef DIV_REMAINDER_EN
        remainder <= rem_neg_r ? ({DV_W{1'b0}} - p_r[DV_W-1:0]) : p_r[DV_W-1:0];
`endif
      end
      if (state == DONE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (DD_W=16, DV_W=8).
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        sign_mode = 1'b0;
  logic [15:0] dd_in = '0;
  logic [7:0]  dv_in = '0;
  logic [15:0] quotient;
  logic        done, div_zero, ovf;
`ifdef DIV_REMAINDER_EN
  logic [7:0]  remainder;
`endif

  int total = 0;
  int bad = 0;

  seq_divider #(.DD_W(16), .DV_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .sign_mode (sign_mode),
    .dd_in     (dd_in),
    .dv_in     (dv_in),
    .quotient  (quotient),
`ifdef DIV_REMAINDER_EN
    .remainder (remainder),
`endif
    .done      (done),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Stimulus only: returns clocks from the go-sampling edge until done is seen high (999 on timeout).
  task automatic do_op(input logic sm, input logic [15:0] dd, input logic [7:0] dv, output int lat);
    sign_mode = sm;
    dd_in     = dd;
    dv_in     = dv;
    go        = 1'b1;
    @(posedge clk);
    #1;
    lat = 999;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    go = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL reset_done got=%b exp=1", done); end
    total++; if (quotient !== 16'h0000) begin bad++; $display("FAIL reset_quot got=%h exp=0000", quotient); end
    total++; if (div_zero !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", div_zero, ovf); end
`ifdef DIV_REMAINDER_EN
    total++; if (remainder !== 8'h00) begin bad++; $display("FAIL reset_rem got=%h exp=00", remainder); end
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned();
    int lat;
    do_op(1'b0, 16'd100, 8'd7, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL u100_7_latency got=%0d exp=18", lat); end
    total++; if (quotient !== 16'd14) begin bad++; $display("FAIL u100_7_quot got=%h exp=000e", quotient); end
    total++; if (div_zero !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL u100_7_flags got=%b%b exp=00", div_zero, ovf); end
`ifdef DIV_REMAINDER_EN
    total++; if (remainder !== 8'd2) begin bad++; $display("FAIL u100_7_rem got=%h exp=02", remainder); end
`endif
  endtask

  task automatic test_signed();
    int lat;
    logic [15:0] dd_v [3] = '{16'hFF9C, 16'h0064, 16'hFF9C};
    logic [7:0]  dv_v [3] = '{8'h07, 8'hF9, 8'hF9};
    logic [15:0] q_v  [3] = '{16'hFFF2, 16'hFFF2, 16'h000E};
    logic [7:0]  r_v  [3] = '{8'hFE, 8'h02, 8'hFE};
    for (int k = 0; k < 3; k++) begin
      do_op(1'b1, dd_v[k], dv_v[k], lat);
      total++; if (lat !== 18) begin bad++; $display("FAIL signed%0d_latency got=%0d exp=18", k, lat); end
      total++; if (quotient !== q_v[k]) begin bad++; $display("FAIL signed%0d_quot got=%h exp=%h", k, quotient, q_v[k]); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL signed%0d_ovf got=%b exp=0", k, ovf); end
`ifdef DIV_REMAINDER_EN
      total++; if (remainder !== r_v[k]) begin bad++; $display("FAIL signed%0d_rem got=%h exp=%h", k, remainder, r_v[k]); end
`endif
    end
  endtask

  task automatic test_div_zero();
    int lat;
    for (int m = 0; m < 2; m++) begin
      do_op(m[0], 16'd55, 8'd0, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL dz%0d_latency got=%0d exp=1", m, lat); end
      total++; if (quotient !== 16'hFFFF) begin bad++; $display("FAIL dz%0d_quot got=%h exp=ffff", m, quotient); end
      total++; if (div_zero !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL dz%0d_flags got=%b%b exp=10", m, div_zero, ovf); end
`ifdef DIV_REMAINDER_EN
      total++; if (remainder !== 8'd55) begin bad++; $display("FAIL dz%0d_rem got=%h exp=37", m, remainder); end
`endif
    end
  endtask

  task automatic test_overflow();
    int lat;
    do_op(1'b1, 16'h8000, 8'hFF, lat);
    total++; if (quotient !== 16'h8000) begin bad++; $display("FAIL smin_quot got=%h exp=8000", quotient); end
    total++; if (ovf !== 1'b1 || div_zero !== 1'b0) begin bad++; $display("FAIL smin_flags got=%b%b exp=01", div_zero, ovf); end
`ifdef DIV_REMAINDER_EN
    total++; if (remainder !== 8'h00) begin bad++; $display("FAIL smin_rem got=%h exp=00", remainder); end
`endif
    do_op(1'b0, 16'h8000, 8'hFF, lat);
    total++; if (quotient !== 16'd128) begin bad++; $display("FAIL umin_quot got=%h exp=0080", quotient); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL umin_ovf got=%b exp=0", ovf); end
`ifdef DIV_REMAINDER_EN
    total++; if (remainder !== 8'd128) begin bad++; $display("FAIL umin_rem got=%h exp=80", remainder); end
`endif
  endtask

  task automatic test_back_to_back();
    int lows;
    int lat;
    sign_mode = 1'b0;
    dd_in     = 16'd1000;
    dv_in     = 8'd10;
    go        = 1'b1;
    lows      = 0;
    @(posedge clk);
    #1;
    dd_in = 16'd5000;
    for (int i = 0; i < 40; i++) begin
      if (!done) lows++;
      @(posedge clk);
      #1;
    end
    total++; if (lows !== 18) begin bad++; $display("FAIL hold_busy_cycles got=%0d exp=18", lows); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL hold_done got=%b exp=1", done); end
    total++; if (quotient !== 16'd100) begin bad++; $display("FAIL hold_quot got=%h exp=0064", quotient); end
    go = 1'b0;
    @(posedge clk);
    #1;
    total++; if (done !== 1'b1 || quotient !== 16'd100) begin bad++; $display("FAIL idle_hold got=%b/%h exp=1/0064", done, quotient); end
    do_op(1'b0, 16'd5000, 8'd10, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL restart_latency got=%0d exp=18", lat); end
    total++; if (quotient !== 16'd500) begin bad++; $display("FAIL restart_quot got=%h exp=01f4", quotient); end
  endtask

  task automatic test_reset_mid();
    int lat;
    sign_mode = 1'b0;
    dd_in     = 16'd100;
    dv_in     = 8'd7;
    go        = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    go    = 1'b0;
    @(posedge clk);
    #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL midrst_done got=%b exp=1", done); end
    total++; if (quotient !== 16'h0000) begin bad++; $display("FAIL midrst_quot got=%h exp=0000", quotient); end
    total++; if (div_zero !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b%b exp=00", div_zero, ovf); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_op(1'b1, 16'hFF9C, 8'h07, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL postrst_latency got=%0d exp=18", lat); end
    total++; if (quotient !== 16'hFFF2) begin bad++; $display("FAIL postrst_quot got=%h exp=fff2", quotient); end
`ifdef DIV_REMAINDER_EN
    total++; if (remainder !== 8'hFE) begin bad++; $display("FAIL postrst_rem got=%h exp=fe", remainder); end
`endif
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
